// File: rtl/mixer_sequencer_pkg.sv
// Shared definitions for the mixer sequencer: FSM encoding and
// channel-count constants used to size the reduction counters.
package mixer_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REDUCE = 2'd1,
        ST_DONE   = 2'd2
    } mix_state_e;

    localparam int MIX_DEF_CHANNELS = 8;

    // Ceiling log2, usable in constant expressions.
    function automatic int mix_log2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    localparam int MIX_DEF_LOG2 = mix_log2(MIX_DEF_CHANNELS);

endpackage

// File: rtl/mixer_sequencer_mixer.sv
// Two-input averaging mixer: y = (a + b) >>> 1 at DATA_BITS+1 width.
// The average of two in-range values is always in range, so the
// top bit of the shifted sum is a pure sign copy and can be dropped.
module mixer_sequencer_mixer #(
    parameter int DATA_BITS = 12
) (
    input  logic signed [DATA_BITS-1:0] a,
    input  logic signed [DATA_BITS-1:0] b,
    output logic signed [DATA_BITS-1:0] y
);

    logic signed [DATA_BITS:0] sum;

    // Sign-extend both operands, add, then floor-divide by two.
    always_comb begin
        sum = {a[DATA_BITS-1], a} + {b[DATA_BITS-1], b};
        y   = sum[DATA_BITS:1];
    end

endmodule

// File: rtl/mixer_sequencer.sv
// Mixer sequencer: captures NUM_CHANNELS samples on a strobe and reduces
// them pairwise through a single shared averaging mixer, one op per cycle,
// producing the balanced-tree average after NUM_CHANNELS-1 ops.
module mixer_sequencer
    import mixer_sequencer_pkg::*;
#(
    parameter int NUM_CHANNELS = MIX_DEF_CHANNELS,
    parameter int DATA_BITS    = 12
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              sample_strobe,
    input  logic [NUM_CHANNELS-1:0]           channel_enable,
    input  logic [NUM_CHANNELS*DATA_BITS-1:0] din,
    output logic signed [DATA_BITS-1:0]       dout,
    output logic                              dout_valid,
    output logic                              busy,
    output logic                              overrun
);

    localparam int LOG2 = mix_log2(NUM_CHANNELS);

    mix_state_e                             state_q, state_d;
    logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] buf_q;
    logic [LOG2-1:0]                        k_q, a_idx, b_idx;
    logic [LOG2:0]                          m_q, half_m;
    logic                                   last_op, final_op, accept;
    logic signed [DATA_BITS-1:0]            mix_a, mix_b, mix_y;

    // Op k reads entries 2k and 2k+1 of the current level and writes entry k;
    // writes never land on an entry still to be read in the same level.
    assign a_idx    = k_q << 1;
    assign b_idx    = a_idx | LOG2'(1);
    assign half_m   = m_q >> 1;
    assign last_op  = ({1'b0, k_q} == half_m - 1'b1);
    assign final_op = (state_q == ST_REDUCE) && (m_q == (LOG2+1)'(2));
    assign accept   = (state_q != ST_REDUCE) && sample_strobe;
    assign mix_a    = buf_q[a_idx];
    assign mix_b    = buf_q[b_idx];

    mixer_sequencer_mixer #(
        .DATA_BITS (DATA_BITS)
    ) u_mix (
        .a (mix_a),
        .b (mix_b),
        .y (mix_y)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic: DONE accepts a strobe exactly like IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: state_d = accept ? ST_REDUCE : ST_IDLE;
            ST_REDUCE:        state_d = final_op ? ST_DONE : ST_REDUCE;
            default:          state_d = ST_IDLE;
        endcase
    end

    // Outputs decoded from state: busy covers the reduction only.
    always_comb begin
        busy = (state_q == ST_REDUCE);
    end

    // Datapath: sample capture, reduction ops, result and pulse registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            k_q        <= '0;
            m_q        <= (LOG2+1)'(NUM_CHANNELS);
            dout       <= '0;
            dout_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            dout_valid <= 1'b0;
            overrun    <= 1'b0;
            case (state_q)
                ST_REDUCE: begin
                    overrun <= sample_strobe;
                    if (final_op) begin
                        dout       <= mix_y;
                        dout_valid <= 1'b1;
                    end else begin
                        buf_q[k_q] <= mix_y;
                    end
                    if (last_op) begin
                        m_q <= half_m;
                        k_q <= '0;
                    end else begin
                        k_q <= k_q + 1'b1;
                    end
                end
                default: begin
                    if (accept) begin
                        for (int i = 0; i < NUM_CHANNELS; i++) begin
                            buf_q[i] <= channel_enable[i] ? din[i*DATA_BITS +: DATA_BITS] : '0;
                        end
                        k_q <= '0;
                        m_q <= (LOG2+1)'(NUM_CHANNELS);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mixer_sequencer.sv
// Scoreboard bench for mixer_sequencer: stimulus pushes expected results and
// overrun pulses (with the edge they are due on); a negedge monitor pops them.
module tb_mixer_sequencer;

    localparam int N  = 8;
    localparam int DB = 12;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   sample_strobe = 1'b0;
    logic [N-1:0]           channel_enable = '0;
    logic [N*DB-1:0]        din = '0;
    logic signed [DB-1:0]   dout;
    logic                   dout_valid, busy, overrun;

    mixer_sequencer #(.NUM_CHANNELS(N), .DATA_BITS(DB)) dut (
        .clk            (clk),
        .rst            (rst),
        .sample_strobe  (sample_strobe),
        .channel_enable (channel_enable),
        .din            (din),
        .dout           (dout),
        .dout_valid     (dout_valid),
        .busy           (busy),
        .overrun        (overrun)
    );

    always #5 clk = ~clk;

    typedef struct { int val; int cyc; } exp_t;
    exp_t vq[$];
    int   oq[$];

    int   cyc = 0;
    logic rst_q = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;
    int   held = 0;
    int   blo = 1, bhi = 0;   // busy expected when blo <= cyc <= bhi
    int   chv[N];
    logic [N-1:0] env;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst;
    end

    // Reference: balanced-tree average, floor at each level, disabled = 0.
    function automatic int tree_avg(input int v[N], input logic [N-1:0] en);
        int cur[N];
        int nxt[N];
        int m;
        for (int i = 0; i < N; i++) cur[i] = en[i] ? v[i] : 0;
        m = N;
        while (m > 1) begin
            for (int j = 0; j < m / 2; j++) nxt[j] = (cur[2*j] + cur[2*j+1]) >>> 1;
            m = m / 2;
            for (int j = 0; j < m; j++) cur[j] = nxt[j];
        end
        return cur[0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Issue one strobe with chv/env; predicts accept, overrun or nothing.
    task automatic strobe_go();
        int e;
        exp_t x;
        e = cyc + 1;
        for (int i = 0; i < N; i++) din[i*DB +: DB] = chv[i][DB-1:0];
        channel_enable = env;
        sample_strobe = 1'b1;
        if (!rst) begin
            if (e - 1 >= blo && e - 1 <= bhi) begin
                oq.push_back(e);
            end else begin
                x.val = tree_avg(chv, env);
                x.cyc = e + N - 1;
                vq.push_back(x);
                blo = e;
                bhi = e + N - 2;
            end
        end
        tick();
        sample_strobe = 1'b0;
        din = {$urandom, $urandom, $urandom};
        channel_enable = N'($urandom);
    endtask

    task automatic do_reset(input int ncyc);
        int e;
        e = cyc + 1;
        rst = 1'b1;
        vq.delete();
        oq.delete();
        if (bhi > e - 1) bhi = e - 1;
        repeat (ncyc) tick();
        rst = 1'b0;
    endtask

    task automatic fill(input int v, input logic [N-1:0] en);
        for (int i = 0; i < N; i++) chv[i] = v;
        env = en;
    endtask

    // Monitor: pops expectations, checks held dout and busy every cycle.
    always @(negedge clk) begin
        exp_t e;
        int   oc;
        if (rst_q) held = 0;
        while (vq.size() > 0 && vq[0].cyc < cyc) begin
            e = vq.pop_front();
            n_chk++; n_fail++;
            $display("FAIL valid_missing: no dout_valid at edge %0d, required value %0d", e.cyc, e.val);
        end
        while (oq.size() > 0 && oq[0] < cyc) begin
            oc = oq.pop_front();
            n_chk++; n_fail++;
            $display("FAIL overrun_missing: no overrun at edge %0d", oc);
        end
        if (dout_valid) begin
            n_chk++;
            if (vq.size() == 0) begin
                n_fail++;
                $display("FAIL valid_unexpected: dout_valid at edge %0d dout=%0d, required none", cyc, dout);
            end else begin
                e = vq.pop_front();
                if (e.cyc != cyc || e.val != int'(dout)) begin
                    n_fail++;
                    $display("FAIL result: edge %0d dout=%0d, required edge %0d dout=%0d", cyc, dout, e.cyc, e.val);
                end
                held = e.val;
            end
        end
        if (overrun) begin
            n_chk++;
            if (oq.size() == 0) begin
                n_fail++;
                $display("FAIL overrun_unexpected: overrun at edge %0d, required none", cyc);
            end else begin
                oc = oq.pop_front();
                if (oc != cyc) begin
                    n_fail++;
                    $display("FAIL overrun_edge: overrun at edge %0d, required edge %0d", cyc, oc);
                end
            end
        end
        n_chk++;
        if (int'(dout) != held) begin
            n_fail++;
            $display("FAIL dout_hold: edge %0d dout=%0d, required %0d", cyc, dout, held);
        end
        n_chk++;
        if (busy != (cyc >= blo && cyc <= bhi)) begin
            n_fail++;
            $display("FAIL busy: edge %0d busy=%0b, required %0b", cyc, busy, (cyc >= blo && cyc <= bhi));
        end
    end

    initial begin
        int r;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Uniform levels, extremes, floor truncation.
        fill(800, '1);   strobe_go(); repeat (9) tick();
        fill(2047, '1);  strobe_go(); repeat (9) tick();
        fill(-2048, '1); strobe_go(); repeat (9) tick();
        fill(0, 8'h01); chv[0] = 1024; env = '1 ^ 8'hFE; strobe_go(); repeat (9) tick();
        fill(0, '1); chv[0] = 1;  strobe_go(); repeat (9) tick();
        fill(0, '1); chv[0] = -1; strobe_go(); repeat (9) tick();

        // Second strobe three edges into a mix: overrun, first result intact.
        fill(300, '1); chv[5] = -700; strobe_go(); repeat (2) tick();
        fill(1500, '1); strobe_go(); repeat (9) tick();

        // Reset four edges into a mix aborts it; next mix is clean.
        fill(1000, '1); strobe_go(); repeat (3) tick();
        do_reset(1); repeat (3) tick();
        fill(-37, '1); chv[2] = 999; strobe_go(); repeat (9) tick();

        // Back-to-back: second strobe lands in the DONE cycle.
        fill(100, '1); strobe_go(); repeat (7) tick();
        fill(-100, 8'hA5); strobe_go(); repeat (9) tick();

        // Reset wins over a simultaneous strobe.
        rst = 1'b1; fill(555, '1); strobe_go(); rst = 1'b0;
        if (bhi > cyc - 1) bhi = cyc - 1;
        repeat (3) tick();

        // Randomised traffic with occasional overruns and resets.
        for (int it = 0; it < 80; it++) begin
            env = N'($urandom);
            for (int i = 0; i < N; i++) chv[i] = int'($urandom_range(0, 4095)) - 2048;
            strobe_go();
            r = $urandom_range(0, 9);
            if (r == 0) begin
                repeat ($urandom_range(0, 5)) tick();
                strobe_go();
            end else if (r == 1) begin
                repeat ($urandom_range(0, 6)) tick();
                do_reset($urandom_range(1, 2));
            end
            repeat ($urandom_range(0, N + 2)) tick();
        end

        repeat (N + 3) tick();
        n_chk++;
        if (vq.size() != 0 || oq.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d results and %0d overruns still pending, required 0", vq.size(), oq.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
